udp_dram_burst_recv: RTL and testbench
======================================

UDP_DRAM_BURST_RECV -- requirements
Module: udp_dram_burst_recv

Interface
REQ-001 SHALL have parameter HDR_WORDS, default 4: header words preceding the address word.
REQ-002 SHALL have parameter LEN_IDX, default 3: index of the header word holding the payload byte length.
REQ-003 SHALL have parameter MAX_BURST, default 64 (legal 1..255): maximum words per DRAM command.
REQ-004 SHALL have parameter MAX_BYTES, default 32'h0000_2000: largest accepted payload byte length.
REQ-005 SHALL have parameter ADDR_SHIFT, default 2: left shift from word address to byte address.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 r_req, r_enable  in  1 each  stream request / packet-active, high for the whole packet.
REQ-009 r_ack  out  1  tied high.
REQ-010 r_data  in  32  stream word, valid every cycle r_enable is high.
REQ-011 w_req, w_enable  out  1 each  tied low; w_ack in 1 ignored; w_data out 32 held 0.
REQ-012 data_in  out  36  {strb[3:0], data[31:0]} to DRAM data FIFO.
REQ-013 data_we  out  1  data FIFO write strobe.
REQ-014 ctrl_in  out  40  {len_words[7:0], byte_addr[31:0]} to DRAM command FIFO.
REQ-015 ctrl_we  out  1  command FIFO write strobe, single-cycle pulse.
REQ-016 pkt_count, drop_count, trunc_count  out  16 each  wrapping event counters.

Function
REQ-017 SHALL register r_data into r_data_reg every cycle; all parsing uses r_data_reg (one-cycle lag).
REQ-018 FSM states: IDLE, HEADER, ADDR, DATA, FLUSH, WAIT_END.
REQ-019 IDLE -> HEADER when r_enable=1; HEADER lasts exactly HDR_WORDS cycles, capturing r_data_reg into header[0..HDR_WORDS-1].
REQ-020 ADDR (1 cycle): base <= r_data_reg; total_words <= ceil(header[LEN_IDX]/4) (32-bit arithmetic, no overflow for lengths <= MAX_BYTES).
REQ-021 ADDR -> WAIT_END when length==0 (pkt_count+1, no data, no command).
REQ-022 ADDR -> WAIT_END when length>MAX_BYTES (drop_count+1, no data_we, no ctrl_we).
REQ-023 Otherwise ADDR -> DATA; in DATA data_we=1 and data_in={strb, r_data_reg} each cycle, word counter wcnt increments.
REQ-024 strb SHALL be 4'b1111 except on the final word: length[1:0]=1 -> 0001, 2 -> 0011, 3 -> 0111, 0 -> 1111.
REQ-025 Burst split: after every MAX_BURST data words, or after the final word, ctrl_we SHALL pulse on the next cycle.
REQ-026 ctrl_in len = words in that burst (1..MAX_BURST); addr = (base<<ADDR_SHIFT) + 4*(words written before this burst), modulo 2^32.
REQ-027 DATA -> FLUSH after the final word (wcnt reaches total_words); FLUSH emits the last ctrl_we, pkt_count+1, then -> WAIT_END.
REQ-028 r_enable low while in HEADER/ADDR: -> IDLE, no outputs, trunc_count+1.
REQ-029 r_enable low in DATA (truncation): data_we stops that cycle; words already written SHALL get their ctrl_we in FLUSH (none if zero); trunc_count+1, pkt_count unchanged; FLUSH -> IDLE.
REQ-030 WAIT_END -> IDLE when r_enable=0; extra words beyond total_words SHALL be discarded.
REQ-031 A new packet SHALL be accepted only from IDLE; r_enable must drop for >=1 cycle between packets.
REQ-032 ctrl_we and data_we SHALL never be asserted in the same cycle for the same burst boundary; command always follows its last data word.
REQ-033 Counters wrap 16'hFFFF -> 0.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, data_we=0, ctrl_we=0, data_in=0, ctrl_in=0, all counters 0, wcnt 0.
REQ-035 Reset mid-packet SHALL discard the packet with no further strobes; after release, the module waits for r_enable low then high before parsing.

Verification
REQ-036 Len 16, addr 0x100, MAX_BURST 64 -> 4 data_we, strb 1111, one ctrl_in={8'd4, 32'h400}, pkt_count=1.
REQ-037 Len 130 -> 33 words, last strb 0011, ctrl_in={8'd33, base<<2}.
REQ-038 MAX_BURST=8, len 80, addr 0 -> 20 words, ctrl_in {8,0x0},{8,0x20},{4,0x40} in order, each after its last word.
REQ-039 Len 0x4000 > MAX_BYTES -> zero strobes, drop_count=1; next valid packet processed normally.
REQ-040 Len 64, r_enable drops after 5 data words -> 5 data_we, one ctrl_in={8'd5, base<<2}, trunc_count=1, pkt_count=0.
REQ-041 rst pulse during DATA, then full packet -> no strobes from aborted packet, second packet correct, counters show only second.

Source files
------------

// File: rtl/udp_dram_burst_recv_if.sv
// udp_dram_burst_recv_if: bundles the stream-in port and the DRAM data/command FIFO writes.
//   slave  : receiver side (stream in, FIFO writes out)
//   master : source/monitor side
//   r_req, r_enable, r_data : stream request, packet-active, word
//   r_ack                   : stream acknowledge
//   w_req, w_enable, w_ack, w_data : unused write-back stream
//   data_in/data_we         : {strb, data} to the DRAM data FIFO
//   ctrl_in/ctrl_we         : {len_words, byte_addr} to the DRAM command FIFO
interface udp_dram_burst_recv_if;
    logic        r_req;
    logic        r_enable;
    logic        r_ack;
    logic [31:0] r_data;
    logic        w_req;
    logic        w_enable;
    logic        w_ack;
    logic [31:0] w_data;
    logic [35:0] data_in;
    logic        data_we;
    logic [39:0] ctrl_in;
    logic        ctrl_we;
    modport slave (
        input  r_req, r_enable, r_data, w_ack,
        output r_ack, w_req, w_enable, w_data, data_in, data_we, ctrl_in, ctrl_we
    );
    modport master (
        output r_req, r_enable, r_data, w_ack,
        input  r_ack, w_req, w_enable, w_data, data_in, data_we, ctrl_in, ctrl_we
    );
endinterface

// File: rtl/udp_dram_burst_recv.sv
// udp_dram_burst_recv: parses a header/address/payload stream and writes it to DRAM FIFOs in bursts.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : stream input plus data/command FIFO write ports
//   pkt_count     : completed (or zero-length) packets
//   drop_count    : packets rejected for oversize length
//   trunc_count   : packets cut short by r_enable falling early
module udp_dram_burst_recv #(
    parameter int          HDR_WORDS  = 4,
    parameter int          LEN_IDX    = 3,
    parameter int          MAX_BURST  = 64,
    parameter logic [31:0] MAX_BYTES  = 32'h0000_2000,
    parameter int          ADDR_SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    udp_dram_burst_recv_if.slave   bus,
    output logic [15:0]            pkt_count,
    output logic [15:0]            drop_count,
    output logic [15:0]            trunc_count
);
    localparam int HW = HDR_WORDS > 1 ? $clog2(HDR_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, HEADER, ADDR, DATA, FLUSH, WAIT_END} state_t;

    state_t        state, state_n;
    logic [31:0]   r_data_reg;
    logic [31:0]   header [HDR_WORDS];
    logic [31:0]   len, total_words, wcnt, burst_addr;
    logic [HW-1:0] hcnt;
    logic [7:0]    bcnt, ctrl_len;
    logic [3:0]    strb;
    logic [39:0]   ctrl_in;
    logic          ctrl_we, en_reg, armed, truncd;
    logic          data_we, last, emit, pkt_inc, drop_inc, trunc_inc;
    logic          unused_ok;

    assign bus.r_ack    = 1'b1;
    assign bus.w_req    = 1'b0;
    assign bus.w_enable = 1'b0;
    assign bus.w_data   = 32'd0;
    assign unused_ok    = bus.r_req ^ bus.w_ack;

    assign len      = header[LEN_IDX];
    assign strb     = !last ? 4'b1111 :
                      len[1:0] == 2'd1 ? 4'b0001 :
                      len[1:0] == 2'd2 ? 4'b0011 :
                      len[1:0] == 2'd3 ? 4'b0111 : 4'b1111;
    // On truncation no word is written this cycle, so the burst holds bcnt words.
    assign ctrl_len = en_reg ? bcnt + 8'd1 : bcnt;

    assign bus.data_we = data_we;
    assign bus.data_in = data_we ? {strb, r_data_reg} : 36'd0;
    assign bus.ctrl_we = ctrl_we;
    assign bus.ctrl_in = ctrl_in;

    // en_reg marks r_data_reg as valid, so every parsing state tests en_reg;
    // only IDLE and WAIT_END look at the live r_enable to find packet edges.
    always_comb begin
        state_n   = state;
        data_we   = 1'b0;
        last      = 1'b0;
        emit      = 1'b0;
        pkt_inc   = 1'b0;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        case (state)
            IDLE: state_n = (bus.r_enable && armed) ? HEADER : IDLE;
            HEADER: begin
                trunc_inc = !en_reg;
                state_n   = !en_reg ? IDLE : (hcnt == HW'(HDR_WORDS - 1)) ? ADDR : HEADER;
            end
            ADDR: begin
                trunc_inc = !en_reg;
                pkt_inc   = en_reg && len == 32'd0;
                drop_inc  = en_reg && len > MAX_BYTES;
                state_n   = !en_reg ? IDLE : (len == 32'd0 || len > MAX_BYTES) ? WAIT_END : DATA;
            end
            DATA: begin
                data_we   = en_reg;
                trunc_inc = !en_reg;
                last      = en_reg && wcnt + 32'd1 == total_words;
                emit      = en_reg ? (last || bcnt + 8'd1 == 8'(MAX_BURST)) : bcnt != 8'd0;
                state_n   = (!en_reg || last) ? FLUSH : DATA;
            end
            FLUSH: begin
                pkt_inc = !truncd;
                state_n = truncd ? IDLE : WAIT_END;
            end
            WAIT_END: state_n = bus.r_enable ? WAIT_END : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Commands are registered so each one lands the cycle after its last data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            r_data_reg  <= 32'd0;
            en_reg      <= 1'b0;
            armed       <= 1'b0;
            truncd      <= 1'b0;
            hcnt        <= '0;
            total_words <= 32'd0;
            wcnt        <= 32'd0;
            bcnt        <= 8'd0;
            burst_addr  <= 32'd0;
            ctrl_we     <= 1'b0;
            ctrl_in     <= 40'd0;
            pkt_count   <= 16'd0;
            drop_count  <= 16'd0;
            trunc_count <= 16'd0;
        end else begin
            state      <= state_n;
            r_data_reg <= bus.r_data;
            en_reg     <= bus.r_enable;
            armed      <= armed | !bus.r_enable;
            hcnt       <= state == HEADER ? hcnt + 1'b1 : '0;
            if (state == ADDR) begin
                total_words <= (len + 32'd3) >> 2;
                burst_addr  <= r_data_reg << ADDR_SHIFT;
                wcnt        <= 32'd0;
                bcnt        <= 8'd0;
            end
            if (state == DATA)
                truncd <= !en_reg;
            if (data_we) begin
                wcnt <= wcnt + 32'd1;
                bcnt <= bcnt + 8'd1;
            end
            ctrl_we <= emit;
            if (emit) begin
                ctrl_in    <= {ctrl_len, burst_addr};
                burst_addr <= burst_addr + {22'd0, ctrl_len, 2'b00};
                bcnt       <= 8'd0;
            end
            pkt_count   <= pkt_count + {15'd0, pkt_inc};
            drop_count  <= drop_count + {15'd0, drop_inc};
            trunc_count <= trunc_count + {15'd0, trunc_inc};
        end
    end

    always_ff @(posedge clk)
        if (state == HEADER)
            header[hcnt] <= r_data_reg;
endmodule

// File: tb/tb_udp_dram_burst_recv.sv
// tb_udp_dram_burst_recv: random and directed packets against a queue-based payload/burst model.
module tb_udp_dram_burst_recv;
    localparam int          HDR  = 4;
    localparam logic [31:0] MAXB = 32'h2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pkt0, drop0, trunc0, pkt8, drop8, trunc8;

    udp_dram_burst_recv_if bus0();
    udp_dram_burst_recv_if bus8();

    udp_dram_burst_recv dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .pkt_count(pkt0), .drop_count(drop0), .trunc_count(trunc0)
    );
    udp_dram_burst_recv #(.MAX_BURST(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .pkt_count(pkt8), .drop_count(drop8), .trunc_count(trunc8)
    );

    assign bus8.r_req    = bus0.r_req;
    assign bus8.r_enable = bus0.r_enable;
    assign bus8.r_data   = bus0.r_data;
    assign bus8.w_ack    = bus0.w_ack;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [35:0] dq0[$], dq8[$];
    logic [39:0] cq0[$], cq8[$];
    int          sq0[$], sq8[$];

    logic [31:0] words[$];
    logic [31:0] cur_len, cur_addr, len, addr;
    int          cur_nw, sel, nw, tot;
    logic [15:0] m_pkt = 0, m_drop = 0, m_trunc = 0;

    // Snapshot the data count before logging same-cycle data, so a command
    // issued alongside its own last word shows up as an ordering error.
    always @(negedge clk) begin
        if (bus0.ctrl_we) begin sq0.push_back(dq0.size()); cq0.push_back(bus0.ctrl_in); end
        if (bus0.data_we) dq0.push_back(bus0.data_in);
        if (bus8.ctrl_we) begin sq8.push_back(dq8.size()); cq8.push_back(bus8.ctrl_in); end
        if (bus8.data_we) dq8.push_back(bus8.data_in);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_q();
        dq0.delete(); cq0.delete(); sq0.delete();
        dq8.delete(); cq8.delete(); sq8.delete();
    endtask

    task automatic compare(input string nm, input int mb, input logic [35:0] ad[$],
                           input logic [39:0] ac[$], input int as[$],
                           input logic [15:0] pc, input logic [15:0] dc, input logic [15:0] tc);
        int          total, nd, w, nb, done, l;
        logic [3:0]  s;
        logic [31:0] a;
        nd    = cur_nw - HDR - 1;
        total = int'((64'(cur_len) + 64'd3) / 64'd4);
        w     = 0;
        if (cur_nw > HDR && cur_len != 0 && cur_len <= MAXB) w = nd < total ? nd : total;
        check({nm, " data count"}, 64'(ad.size()), 64'(w));
        for (int i = 0; i < w && i < ad.size(); i++) begin
            s = (i == total - 1 && cur_len % 4 != 0) ? 4'((1 << (cur_len % 4)) - 1) : 4'hF;
            check({nm, " data word"}, 64'(ad[i]), 64'({s, words[i]}));
        end
        nb = (w + mb - 1) / mb;
        check({nm, " cmd count"}, 64'(ac.size()), 64'(nb));
        done = 0;
        for (int b = 0; b < nb && b < ac.size(); b++) begin
            l = (w - done) < mb ? (w - done) : mb;
            a = (cur_addr << 2) + 32'(4 * done);
            check({nm, " cmd"}, 64'(ac[b]), 64'({8'(l), a}));
            done += l;
            check({nm, " cmd order"}, 64'(as[b]), 64'(done));
        end
        check({nm, " pkt_count"}, 64'(pc), 64'(m_pkt));
        check({nm, " drop_count"}, 64'(dc), 64'(m_drop));
        check({nm, " trunc_count"}, 64'(tc), 64'(m_trunc));
    endtask

    task automatic send_pkt(input logic [31:0] plen, input logic [31:0] paddr, input int pnw);
        logic [31:0] w;
        int          nd;
        cur_len = plen; cur_addr = paddr; cur_nw = pnw;
        words.delete();
        for (int i = 0; i < pnw; i++) begin
            w = $urandom;
            if (i == 3) w = plen;
            else if (i == HDR) w = paddr;
            else if (i > HDR) words.push_back(w);
            bus0.r_enable = 1'b1;
            bus0.r_data   = w;
            @(posedge clk); #1;
        end
        bus0.r_enable = 1'b0;
        bus0.r_data   = $urandom;
        repeat (6) @(posedge clk);
        #1;
        nd = pnw - HDR - 1;
        if (pnw <= HDR) m_trunc++;
        else if (plen == 0) m_pkt++;
        else if (plen > MAXB) m_drop++;
        else if (64'(nd) < (64'(plen) + 64'd3) / 64'd4) m_trunc++;
        else m_pkt++;
        compare("mb64", 64, dq0, cq0, sq0, pkt0, drop0, trunc0);
        compare("mb8", 8, dq8, cq8, sq8, pkt8, drop8, trunc8);
        clear_q();
    endtask

    initial begin
        bus0.r_req = 1'b0; bus0.r_enable = 1'b0; bus0.r_data = 32'd0; bus0.w_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("reset data_we", 64'(bus0.data_we), 64'd0);
        check("reset ctrl_we", 64'(bus0.ctrl_we), 64'd0);
        check("reset data_in", 64'(bus0.data_in), 64'd0);
        check("reset ctrl_in", 64'(bus0.ctrl_in), 64'd0);
        check("reset counts", 64'({pkt0, drop0, trunc0}), 64'd0);
        check("r_ack", 64'(bus0.r_ack), 64'd1);
        check("w side", 64'({bus0.w_req, bus0.w_enable, bus0.w_data}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        send_pkt(16, 32'h100, HDR + 1 + 4);
        send_pkt(130, $urandom, HDR + 1 + 33);
        send_pkt(80, 32'h0, HDR + 1 + 20);
        send_pkt(32'h4000, $urandom, HDR + 1 + 3);
        send_pkt(40, 32'h1234, HDR + 1 + 10);
        send_pkt(64, 32'h80, HDR + 1 + 5);
        send_pkt(0, 32'h5, HDR + 1);
        send_pkt(20, 32'h7, 2);
        send_pkt(36, 32'h9, HDR + 1);
        send_pkt(12, 32'h9, HDR + 1 + 3 + 4);
        send_pkt(MAXB, 32'hFFFF_FFF0, HDR + 1 + 2048);
        send_pkt(MAXB + 1, $urandom, HDR + 1 + 2);

        for (int k = 0; k < 40; k++) begin
            sel  = $urandom_range(0, 9);
            addr = $urandom;
            len  = sel == 0 ? 32'd0 : sel == 1 ? MAXB + $urandom_range(1, 32'h100000) : $urandom_range(1, 200);
            tot  = int'((len + 32'd3) >> 2);
            nw   = sel == 1 ? HDR + 1 + $urandom_range(0, 4) :
                   sel == 2 ? HDR + 1 + $urandom_range(0, tot) :
                   sel == 3 ? $urandom_range(1, HDR) :
                   HDR + 1 + tot + $urandom_range(0, 3);
            send_pkt(len, addr, nw);
        end

        for (int i = 0; i < HDR + 4; i++) begin
            bus0.r_enable = 1'b1;
            bus0.r_data   = i == 3 ? 32'd64 : $urandom;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        clear_q();
        @(negedge clk);
        check("midrst data_we", 64'({bus0.data_we, bus8.data_we}), 64'd0);
        check("midrst ctrl_we", 64'({bus0.ctrl_we, bus8.ctrl_we}), 64'd0);
        check("midrst counts", 64'({pkt8, drop8, trunc8}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            bus0.r_data = $urandom;
            @(posedge clk); #1;
        end
        bus0.r_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_pkt = 0; m_drop = 0; m_trunc = 0;
        send_pkt(100, 32'h2000_0000, HDR + 1 + 25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
